// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit initialiser: main-state encoding,
// writer phase encoding, LCD command bytes and the fixed message ROM.
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_POWERUP = 4'd0,
        ST_INIT1   = 4'd1,
        ST_INIT2   = 4'd2,
        ST_INIT3   = 4'd3,
        ST_INIT4   = 4'd4,
        ST_CFG1    = 4'd5,
        ST_CFG2    = 4'd6,
        ST_CFG3    = 4'd7,
        ST_CFG4    = 4'd8,
        ST_MSG1    = 4'd9,
        ST_MSG2    = 4'd10,
        ST_MSG3    = 4'd11,
        ST_MSG4    = 4'd12,
        ST_MSG5    = 4'd13,
        ST_DONE    = 4'd14
    } lcd_state_e;

    localparam logic [2:0] WR_IDLE  = 3'd0;
    localparam logic [2:0] WR_SETUP = 3'd1;
    localparam logic [2:0] WR_EN    = 3'd2;
    localparam logic [2:0] WR_GAP   = 3'd3;
    localparam logic [2:0] WR_POST  = 3'd4;

    localparam logic [7:0] LCD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;

    // Index 0 is the first character sent ("HELLO").
    localparam logic [4:0][7:0] MSG_ROM = {8'h4F, 8'h4C, 8'h4C, 8'h45, 8'h48};

    function automatic logic [7:0] msg_char(input logic [2:0] idx);
        return MSG_ROM[idx];
    endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one LCD transfer (one nibble, or a byte as two nibbles) with
// setup/E/gap timing, then waits the caller-supplied post-wait and pulses done.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_EN      = 12,
    parameter int unsigned T_NIB_GAP = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rs,
    input  logic        two_nibble,
    input  logic [7:0]  xfer_byte,
    input  logic [31:0] post_wait,
    output logic        done,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic [3:0]  lcd_data
);

    logic [2:0]  phase_q, phase_d;
    logic [31:0] cnt_q, cnt_d;
    logic        e_q, e_d;
    logic        rs_q, rs_d;
    logic [3:0]  data_q, data_d;
    logic [3:0]  lo_q, lo_d;
    logic        two_q, two_d;
    logic [31:0] post_q, post_d;
    logic        done_q, done_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        rs_d    = rs_q;
        data_d  = data_q;
        lo_d    = lo_q;
        two_d   = two_q;
        post_d  = post_q;
        done_d  = 1'b0;
        case (phase_q)
            WR_IDLE: begin
                if (start) begin
                    rs_d    = rs;
                    data_d  = xfer_byte[7:4];
                    lo_d    = xfer_byte[3:0];
                    two_d   = two_nibble;
                    post_d  = post_wait;
                    cnt_d   = 32'd0;
                    phase_d = WR_SETUP;
                end
            end
            WR_SETUP: begin
                if (cnt_q == 32'(T_SETUP - 1)) begin
                    e_d     = 1'b1;
                    cnt_d   = 32'd0;
                    phase_d = WR_EN;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WR_EN: begin
                if (cnt_q == 32'(T_EN - 1)) begin
                    e_d     = 1'b0;
                    cnt_d   = 32'd0;
                    phase_d = two_q ? WR_GAP : WR_POST;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WR_GAP: begin
                // RS/data keep the high nibble through the gap, giving hold after E falls.
                if (cnt_q == 32'(T_NIB_GAP - 1)) begin
                    data_d  = lo_q;
                    two_d   = 1'b0;
                    cnt_d   = 32'd0;
                    phase_d = WR_SETUP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WR_POST: begin
                if (cnt_q == post_q - 32'd1) begin
                    done_d  = 1'b1;
                    cnt_d   = 32'd0;
                    phase_d = WR_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                phase_d = WR_IDLE;
                cnt_d   = 32'd0;
                e_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= WR_IDLE;
            cnt_q   <= 32'd0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 4'h0;
            two_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            two_q   <= two_d;
            done_q  <= done_d;
        end
        lo_q   <= lo_d;
        post_q <= post_d;
    end

    assign done     = done_q;
    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

endmodule

// File: rtl/module_lcd_control.sv
// HD44780 4-bit power-up initialiser and "HELLO" writer; sequences transfers
// through lcd_nibble_writer and counts completed transfers on oLed.
module module_lcd_control
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERUP = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000,
    parameter int unsigned T_INIT34  = 2000,
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_EN      = 12,
    parameter int unsigned T_NIB_GAP = 50,
    parameter int unsigned T_CMD     = 2000,
    parameter int unsigned T_CLEAR   = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    output logic [7:0] oLed,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_StrataFlashControl,
    output logic       oLCD_ReadWrite,
    output logic [3:0] oLCD_Data
);

    lcd_state_e  state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  led_q, led_d;

    logic        wr_start, wr_rs, wr_two, wr_done;
    logic [7:0]  wr_byte;
    logic [31:0] wr_post;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        led_d   = led_q;
        case (state_q)
            ST_POWERUP: begin
                if (timer_q == 32'(T_POWERUP - 1)) begin
                    state_d = ST_INIT1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                if (wr_done) begin
                    state_d = lcd_state_e'(state_q + 4'd1);
                    if (led_q != 8'hFF) begin
                        led_d = led_q + 8'd1;
                    end
                end
            end
        endcase
    end

    // The next transfer is launched on the same cycle the state advances into it.
    always_comb begin
        wr_start = (state_d != state_q) && (state_d != ST_DONE);
        wr_rs    = 1'b0;
        wr_two   = 1'b1;
        wr_byte  = 8'h00;
        wr_post  = 32'(T_CMD);
        case (state_d)
            ST_INIT1: begin wr_two = 1'b0; wr_byte = 8'h30; wr_post = 32'(T_INIT1);  end
            ST_INIT2: begin wr_two = 1'b0; wr_byte = 8'h30; wr_post = 32'(T_INIT2);  end
            ST_INIT3: begin wr_two = 1'b0; wr_byte = 8'h30; wr_post = 32'(T_INIT34); end
            ST_INIT4: begin wr_two = 1'b0; wr_byte = 8'h20; wr_post = 32'(T_INIT34); end
            ST_CFG1:  wr_byte = LCD_FUNC_SET;
            ST_CFG2:  wr_byte = LCD_ENTRY;
            ST_CFG3:  wr_byte = LCD_DISP_ON;
            ST_CFG4:  begin wr_byte = LCD_CLEAR; wr_post = 32'(T_CLEAR); end
            ST_MSG1:  begin wr_rs = 1'b1; wr_byte = msg_char(3'd0); end
            ST_MSG2:  begin wr_rs = 1'b1; wr_byte = msg_char(3'd1); end
            ST_MSG3:  begin wr_rs = 1'b1; wr_byte = msg_char(3'd2); end
            ST_MSG4:  begin wr_rs = 1'b1; wr_byte = msg_char(3'd3); end
            ST_MSG5:  begin wr_rs = 1'b1; wr_byte = msg_char(3'd4); end
            default:  wr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_POWERUP;
            timer_q <= 32'd0;
            led_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            led_q   <= led_d;
        end
    end

    lcd_nibble_writer #(
        .T_SETUP   (T_SETUP),
        .T_EN      (T_EN),
        .T_NIB_GAP (T_NIB_GAP)
    ) u_writer (
        .clk        (Clock),
        .rst        (Reset),
        .start      (wr_start),
        .rs         (wr_rs),
        .two_nibble (wr_two),
        .xfer_byte  (wr_byte),
        .post_wait  (wr_post),
        .done       (wr_done),
        .lcd_e      (oLCD_Enabled),
        .lcd_rs     (oLCD_RegisterSelect),
        .lcd_data   (oLCD_Data)
    );

    assign oLed                    = led_q;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_ReadWrite          = 1'b0;

endmodule

// File: tb/tb_module_lcd_control.sv
// Bench for module_lcd_control with shrunk timing parameters: a scoreboard of
// expected E pulses (RS, nibble, preceding low gap, oLed) checked by a pin monitor.
module tb_module_lcd_control;

    localparam int TP   = 20;
    localparam int TI1  = 30;
    localparam int TI2  = 15;
    localparam int TI34 = 10;
    localparam int TS   = 2;
    localparam int TE   = 3;
    localparam int TG   = 4;
    localparam int TC   = 12;
    localparam int TCL  = 40;
    // One cycle of done handshake separates a post-wait from the next start.
    localparam int HANDOFF = 1;

    localparam logic [3:0][3:0]  INIT_NIB  = {4'h2, 4'h3, 4'h3, 4'h3};
    localparam logic [3:0][31:0] INIT_POST = {32'(TI34), 32'(TI34), 32'(TI2), 32'(TI1)};
    localparam logic [8:0][7:0]  BYTES     = {8'h4F, 8'h4C, 8'h4C, 8'h45, 8'h48,
                                              8'h01, 8'h0C, 8'h06, 8'h28};
    localparam logic [8:0][31:0] BYTE_POST = {32'(TC), 32'(TC), 32'(TC), 32'(TC), 32'(TC),
                                              32'(TCL), 32'(TC), 32'(TC), 32'(TC)};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] led;
    logic       e, rs_o, sf, rw;
    logic [3:0] d_o;

    always #5 clk = ~clk;

    module_lcd_control #(
        .T_POWERUP (TP), .T_INIT1 (TI1), .T_INIT2 (TI2), .T_INIT34 (TI34),
        .T_SETUP (TS), .T_EN (TE), .T_NIB_GAP (TG), .T_CMD (TC), .T_CLEAR (TCL)
    ) dut (
        .Clock                   (clk),
        .Reset                   (rst),
        .oLed                    (led),
        .oLCD_Enabled            (e),
        .oLCD_RegisterSelect     (rs_o),
        .oLCD_StrataFlashControl (sf),
        .oLCD_ReadWrite          (rw),
        .oLCD_Data               (d_o)
    );

    typedef struct {
        logic       rs;
        logic [3:0] nib;
        int         gap;
        int         led;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_pulse(input logic rs, input logic [3:0] nib, input int gap, input int k);
        exp_t x;
        x.rs  = rs;
        x.nib = nib;
        x.gap = gap;
        x.led = k;
        q.push_back(x);
    endtask

    // Expected pulse train for one complete power-up sequence.
    task automatic push_seq();
        int prev_post;
        int k;
        prev_post = -1;
        k = 0;
        q.delete();
        for (int i = 0; i < 4; i++) begin
            push_pulse(1'b0, INIT_NIB[i], (prev_post < 0) ? -1 : prev_post + HANDOFF + TS, k);
            prev_post = int'(INIT_POST[i]);
            k++;
        end
        for (int i = 0; i < 9; i++) begin
            push_pulse(i >= 4, BYTES[i][7:4], prev_post + HANDOFF + TS, k);
            push_pulse(i >= 4, BYTES[i][3:0], TG + TS, k);
            prev_post = int'(BYTE_POST[i]);
            k++;
        end
    endtask

    logic       mon_en = 1'b0;
    logic       prev_e, prev_rs, pulse_rs;
    logic [3:0] prev_d, pulse_d;
    int         low_cnt, hi_cnt, stable;

    always @(negedge clk) begin : monitor
        exp_t x;
        chk("rw_low", rw, 1'b0);
        chk("flash_ctl_high", sf, 1'b1);
        if (!mon_en) begin
            prev_e  = 1'b0;
            low_cnt = 0;
            hi_cnt  = 0;
            stable  = 0;
            prev_rs = rs_o;
            prev_d  = d_o;
        end else begin
            if ({rs_o, d_o} !== {prev_rs, prev_d}) stable = 0;
            else stable++;
            if (e && !prev_e) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    x = q.pop_front();
                    chk("pulse_rs", rs_o, x.rs);
                    chk("pulse_data", d_o, x.nib);
                    chk("pulse_led", led, x.led);
                    if (x.gap >= 0) chk("pulse_gap", low_cnt, x.gap);
                end
                chk("setup_stable", stable >= TS, 1'b1);
                hi_cnt   = 1;
                pulse_rs = rs_o;
                pulse_d  = d_o;
            end else if (e) begin
                hi_cnt++;
            end else if (prev_e) begin
                chk("e_width", hi_cnt, TE);
                chk("hold_rs", rs_o, pulse_rs);
                chk("hold_data", d_o, pulse_d);
                low_cnt = 1;
            end else begin
                low_cnt++;
            end
            prev_e  = e;
            prev_rs = rs_o;
            prev_d  = d_o;
        end
    end

    // Releases reset (already asserted) and follows one full sequence to DONE.
    task automatic run_sequence();
        int cyc;
        int e_hi;
        push_seq();
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        cyc = 0;
        while (!e && cyc < TP + TS + 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("powerup_latency", cyc, TP + TS);
        cyc = 0;
        while (led != 8'd13 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("led_final", led, 8'd13);
        chk("queue_empty", q.size(), 0);
        e_hi = 0;
        repeat (1000) begin
            @(negedge clk);
            if (e) e_hi++;
        end
        chk("done_e_idle", e_hi, 0);
        chk("done_led_hold", led, 8'd13);
    endtask

    initial begin : stim
        int cyc;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_e", e, 1'b0);
        chk("reset_rs", rs_o, 1'b0);
        chk("reset_data", d_o, 4'h0);
        chk("reset_led", led, 8'h00);

        run_sequence();

        // Restart, then abort with Reset while E is high in config byte 2.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        push_seq();
        rst    = 1'b0;
        mon_en = 1'b1;
        cyc = 0;
        while (!(led == 8'd5 && e) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_cfg2_pulse", (led == 8'd5) && e, 1'b1);
        mon_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        chk("abort_e", e, 1'b0);
        chk("abort_led", led, 8'h00);
        chk("abort_rs", rs_o, 1'b0);
        chk("abort_data", d_o, 4'h0);
        repeat (2) @(negedge clk);

        run_sequence();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
